inject_ctrl: RTL and testbench

Local injection controller for a bufferless deflection router. It buffers flits from the local PE in a small FIFO and, each cycle, places the head flit into the lowest-indexed channel slot left free by incoming traffic. It raises a starvation flag when the head flit has been blocked too long. It sits between the PE network interface and the router's permutation/arbitration stage, on the same pipeline stage that sees the per-channel `validIn` vector.

---
 rtl/inject_ctrl.sv | 113 +++++++++++
 tb/tb_inject_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/inject_ctrl.sv
// inject_ctrl: local injection FIFO and lowest-free-slot grant for a deflection router.
// Optional starvation detection is built when INJECT_STARVE_EN is defined.
`ifndef NUM_CHANNEL
`define NUM_CHANNEL 5
`endif

module inject_ctrl #(
  parameter int FLIT_W    = 64,
  parameter int DEPTH     = 4,
  parameter int STARVE_TH = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      peValid,
  input  logic [FLIT_W-1:0]         peFlit,
  output logic                      peReady,
  input  logic [`NUM_CHANNEL-1:0]   validIn,
  output logic [`NUM_CHANNEL-1:0]   injectGrant,
  output logic [FLIT_W-1:0]         injectFlit,
  output logic [$clog2(DEPTH):0]    fifoCount,
  output logic                      starve
);

  localparam int NC = `NUM_CHANNEL;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] TH = 8'(STARVE_TH);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic              w_found;
  logic [NC-1:0]     w_grant;

  assign w_nonempty  = (r_count != '0);
  assign peReady     = (r_count != FULL);
  assign w_push      = peValid & peReady;
  assign w_pop       = |w_grant;
  assign injectGrant = w_grant;
  assign injectFlit  = r_mem[r_rptr];
  assign fifoCount   = r_count;

  // Priority-encode the lowest free slot; nothing granted while empty
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (!w_found && !validIn[i]) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    if (!w_nonempty) w_grant = '0;
  end

  // Flit storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= peFlit;
  end

  // Pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef INJECT_STARVE_EN
  logic [7:0] r_wait;
  logic [7:0] w_wait_nxt;
  logic       r_starve;

  // Consecutive blocked cycles of a waiting head flit, saturating
  always_comb begin
    w_wait_nxt = r_wait;
    if (!w_nonempty || w_pop) w_wait_nxt = '0;
    else if (r_wait != TH)    w_wait_nxt = r_wait + 8'd1;
  end

  // Starvation counter and registered flag updated together
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else begin
      r_wait   <= w_wait_nxt;
      r_starve <= (w_wait_nxt == TH);
    end
  end

  assign starve = r_starve;
`else
  logic w_unused_th;
  assign w_unused_th = ^TH;
  assign starve      = 1'b0;
`endif

endmodule

// File: tb/tb_inject_ctrl.sv
// tb_inject_ctrl: scoreboard bench for inject_ctrl.
// Directed scenarios followed by randomized traffic against a queue model.
`ifndef NUM_CHANNEL
`define NUM_CHANNEL 5
`endif

module tb_inject_ctrl;
  localparam int FW    = 64;
  localparam int DEPTH = 4;
  localparam int TH    = 15;
  localparam int NC    = `NUM_CHANNEL;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   peValid;
  logic [FW-1:0]          peFlit;
  logic                   peReady;
  logic [NC-1:0]          validIn;
  logic [NC-1:0]          injectGrant;
  logic [FW-1:0]          injectFlit;
  logic [$clog2(DEPTH):0] fifoCount;
  logic                   starve;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] sb [$];
  int            m_wait = 0;
  bit            m_starve = 1'b0;
  bit            last_ready = 1'b0;

  always #5 clk = ~clk;

  inject_ctrl #(
    .FLIT_W(FW), .DEPTH(DEPTH), .STARVE_TH(TH)
  ) dut (
    .clk(clk), .reset(reset),
    .peValid(peValid), .peFlit(peFlit), .peReady(peReady),
    .validIn(validIn), .injectGrant(injectGrant),
    .injectFlit(injectFlit), .fifoCount(fifoCount),
    .starve(starve)
  );

  function automatic logic [NC-1:0] lowest_free(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++)
      if (!v[i]) return NC'(1) << i;
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare against the queue model, then advance the model
  always @(negedge clk) begin
    logic [NC-1:0] eg;
    bit pop, push, nonempty;
    nonempty = (sb.size() > 0);
    eg = nonempty ? lowest_free(validIn) : '0;
    chk("peReady", 64'(peReady), 64'(sb.size() < DEPTH));
    chk("fifoCount", 64'(fifoCount), 64'(sb.size()));
    chk("grant", 64'(injectGrant), 64'(eg));
    chk("starve", 64'(starve), 64'(m_starve));
    if (eg != '0) chk("flit", injectFlit, sb[0]);
    last_ready = peReady;
    push = peValid && (sb.size() < DEPTH);
    pop  = (eg != '0);
    if (!reset) begin
      sb.delete();
      m_wait   = 0;
      m_starve = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (!nonempty || pop) m_wait = 0;
      else if (m_wait < TH) m_wait = m_wait + 1;
`ifdef INJECT_STARVE_EN
      m_starve = (m_wait == TH);
`else
      m_starve = 1'b0;
`endif
      if (push) sb.push_back(peFlit);
    end
  end

  task automatic cyc(input bit r, input bit pv, input logic [FW-1:0] f,
                     input logic [NC-1:0] v);
    reset = r; peValid = pv; peFlit = f; validIn = v;
    @(posedge clk); #1;
  endtask

  // Hold an offer until the design takes it, bounded
  task automatic offer(input logic [FW-1:0] f, input logic [NC-1:0] v);
    int n;
    n = 0;
    reset = 1'b1; peValid = 1'b1; peFlit = f; validIn = v;
    do begin
      @(posedge clk);
      n++;
    end while (!last_ready && n < 50);
    if (!last_ready) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: flit %0h not accepted in %0d cycles", f, n);
    end
    #1;
    peValid = 1'b0;
  endtask

  initial begin
    logic [NC-1:0] ones;
    ones = '1;
    reset = 1'b0; peValid = 1'b0; peFlit = '0; validIn = ones;
    // reset with an offer present
    cyc(0, 1, 64'h77, ones);
    cyc(0, 1, 64'h77, ones);
    cyc(1, 0, 0, ones);
    // grant priority
    offer(64'hA5, ones);
    cyc(1, 0, 0, ones);
    cyc(1, 0, 0, ones);
    cyc(1, 0, 0, NC'(5'b00111));
    cyc(1, 0, 0, ones);
    // full and wrap
    for (int k = 1; k <= 4; k++) offer(FW'(k), ones);
    cyc(1, 1, 64'h5, ones);
    cyc(1, 1, 64'h5, ones);
    for (int k = 5; k <= 8; k++) offer(FW'(k), NC'(5'b11110));
    repeat (4) cyc(1, 0, 0, NC'(5'b11110));
    // push and pop together at full
    for (int k = 0; k < 4; k++) offer(FW'(16 + k), ones);
    cyc(1, 1, 64'hBB, '0);
    cyc(1, 1, 64'hBB, ones);
    cyc(1, 0, 0, ones);
    cyc(0, 0, 0, ones);
    // starvation
    offer(64'hC3, ones);
    repeat (20) cyc(1, 0, 0, ones);
    cyc(1, 0, 0, NC'(5'b01111));
    repeat (2) cyc(1, 0, 0, ones);
    // reset mid-operation
    for (int k = 0; k < 3; k++) offer(FW'(32 + k), ones);
    cyc(0, 0, 0, ones);
    repeat (3) cyc(1, 0, 0, '0);
    // randomized traffic
    repeat (400) begin
      logic [NC-1:0] v;
      v = ($urandom_range(0, 2) == 0) ? ones : NC'($urandom);
      cyc($urandom_range(0, 99) != 0, 1'($urandom), {$urandom, $urandom}, v);
    end
    repeat (6) cyc(1, 0, 0, '0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
